// File: rtl/xfer_pkg.sv
// Shared definitions for the register-transfer strobe sequencer:
// command opcodes, sequencer states and settle-count bounds.
package xfer_pkg;

   // Command opcodes; the remaining encodings are reserved and get rejected.
   localparam logic [1:0] OP_MOVE  = 2'd0;
   localparam logic [1:0] OP_CLEAR = 2'd1;

   // Bus settle time, in cycles, before the latch edge.
   localparam int SETTLE_MIN = 1;
   localparam int SETTLE_MAX = 15;
   localparam int CNT_W      = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DRIVE,
      S_LATCH,
      S_RELEASE,
      S_CLEAR,
      S_DONE
   } state_t;

   // Counter load value for the DRIVE phase. Out-of-range settings are
   // clamped so the strobe sequence always keeps its order.
   function automatic logic [CNT_W-1:0] settle_load(input int settle);
      int s;
      s = settle;
      if (s < SETTLE_MIN) s = SETTLE_MIN;
      if (s > SETTLE_MAX) s = SETTLE_MAX;
      return CNT_W'(s - 1);
   endfunction

endpackage

// File: rtl/idx_onehot.sv
// Register index to one-hot select. Indices that name no register,
// or a deasserted enable, give an all-zero vector.
module idx_onehot #(
   parameter int NREGS = 8,
   parameter int IDXW  = 3
) (
   input  logic [IDXW-1:0]  idx,
   input  logic             en,
   output logic [NREGS-1:0] onehot
);

   // Decode the index into a single select bit.
   always_comb begin
      onehot = '0;
      for (int unsigned i = 0; i < NREGS; i++) begin
         if (en && (32'(idx) == i)) onehot[i] = 1'b1;
      end
   end

endmodule

// File: rtl/xfer_sequencer.sv
// Register-transfer strobe sequencer. Takes one MOVE or CLEAR command at a
// time over req/ack and runs drive -> settle -> latch edge -> release.
// Every strobe comes straight from a flop, since the registers treat
// latch and clear as edge/asynchronous inputs.
module xfer_sequencer
   import xfer_pkg::*;
#(
   parameter int NREGS  = 8,
   parameter int IDXW   = 3,
   parameter int SETTLE = 2
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             req,
   input  logic [1:0]       op,
   input  logic [IDXW-1:0]  src,
   input  logic [IDXW-1:0]  dst,
   output logic             ack,
   output logic             err,
   output logic             busy,
   output logic [NREGS-1:0] oe,
   output logic [NREGS-1:0] hold,
   output logic [NREGS-1:0] latch,
   output logic [NREGS-1:0] clr
);

   localparam logic [CNT_W-1:0] SETTLE_LOAD = settle_load(SETTLE);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [IDXW-1:0]  src_q;
   logic [IDXW-1:0]  dst_q;

   logic [IDXW-1:0]  src_sel;
   logic [IDXW-1:0]  dst_sel;
   logic             src_en;
   logic [NREGS-1:0] src_oh;
   logic [NREGS-1:0] dst_oh;
   logic             src_in;
   logic             dst_in;
   logic             cmd_ok;

   // Decode the live command fields while idle and the captured ones
   // afterwards, so the accept edge already loads the first strobe pattern.
   always_comb begin
      src_sel = (state == S_IDLE) ? src : src_q;
      dst_sel = (state == S_IDLE) ? dst : dst_q;
      src_en  = (state != S_IDLE) || (op == OP_MOVE);
   end

   idx_onehot #(
      .NREGS (NREGS),
      .IDXW  (IDXW)
   ) u_src_oh (
      .idx    (src_sel),
      .en     (src_en),
      .onehot (src_oh)
   );

   idx_onehot #(
      .NREGS (NREGS),
      .IDXW  (IDXW)
   ) u_dst_oh (
      .idx    (dst_sel),
      .en     (1'b1),
      .onehot (dst_oh)
   );

   // Command validity check on the live fields at the accept edge.
   always_comb begin
      src_in = 32'(src) < 32'(NREGS);
      dst_in = 32'(dst) < 32'(NREGS);
      cmd_ok = 1'b0;
      if (op == OP_MOVE)  cmd_ok = src_in && dst_in && (src != dst);
      if (op == OP_CLEAR) cmd_ok = dst_in;
   end

   // Sequencer state and registered strobes. Each transition loads the
   // strobe pattern of the state it enters, so outputs track state exactly.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state <= S_IDLE;
         cnt   <= '0;
         src_q <= '0;
         dst_q <= '0;
         ack   <= 1'b0;
         err   <= 1'b0;
         busy  <= 1'b0;
         oe    <= '0;
         hold  <= '1;
         latch <= '0;
         clr   <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               ack <= 1'b0;
               err <= 1'b0;
               if (req) begin
                  src_q <= src;
                  dst_q <= dst;
                  busy  <= 1'b1;
                  if (!cmd_ok) begin
                     state <= S_DONE;
                     ack   <= 1'b1;
                     err   <= 1'b1;
                  end else if (op == OP_MOVE) begin
                     state <= S_DRIVE;
                     cnt   <= SETTLE_LOAD;
                     oe    <= src_oh;
                     hold  <= ~dst_oh;
                  end else begin
                     state <= S_CLEAR;
                     clr   <= dst_oh;
                  end
               end
            end
            S_DRIVE: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  state <= S_LATCH;
                  latch <= dst_oh;
               end
            end
            S_LATCH: begin
               state <= S_RELEASE;
               latch <= '0;
               hold  <= '1;
            end
            S_RELEASE: begin
               state <= S_DONE;
               oe    <= '0;
               ack   <= 1'b1;
            end
            S_CLEAR: begin
               state <= S_DONE;
               clr   <= '0;
               ack   <= 1'b1;
            end
            S_DONE: begin
               state <= S_IDLE;
               ack   <= 1'b0;
               err   <= 1'b0;
               busy  <= 1'b0;
            end
            default: begin
               state <= S_IDLE;
               ack   <= 1'b0;
               err   <= 1'b0;
               busy  <= 1'b0;
               oe    <= '0;
               hold  <= '1;
               latch <= '0;
               clr   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_xfer_sequencer.sv
// Scoreboard bench for xfer_sequencer: stimulus pushes hand-computed
// per-cycle output snapshots tagged with the cycle they are due in; a
// monitor pops and compares them on the falling edge.
module tb_xfer_sequencer;

   logic       CLK = 1'b0;
   logic       RESET;
   logic       req;
   logic [1:0] op;
   logic [2:0] src;
   logic [2:0] dst;
   logic       ack;
   logic       err;
   logic       busy;
   logic [7:0] oe;
   logic [7:0] hold;
   logic [7:0] latch;
   logic [7:0] clr;

   int cyc    = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      int         cyc;
      logic [7:0] oe;
      logic [7:0] hold;
      logic [7:0] latch;
      logic [7:0] clr;
      logic       ack;
      logic       err;
      logic       busy;
      string      tag;
   } exp_t;

   exp_t sb[$];

   xfer_sequencer #(
      .NREGS  (8),
      .IDXW   (3),
      .SETTLE (2)
   ) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .req   (req),
      .op    (op),
      .src   (src),
      .dst   (dst),
      .ack   (ack),
      .err   (err),
      .busy  (busy),
      .oe    (oe),
      .hold  (hold),
      .latch (latch),
      .clr   (clr)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push(input int c, input logic [7:0] e_oe, input logic [7:0] e_hold,
                       input logic [7:0] e_latch, input logic [7:0] e_clr,
                       input logic e_ack, input logic e_err, input logic e_busy,
                       input string tag);
      exp_t e;
      e.cyc = c; e.oe = e_oe; e.hold = e_hold; e.latch = e_latch; e.clr = e_clr;
      e.ack = e_ack; e.err = e_err; e.busy = e_busy; e.tag = tag;
      sb.push_back(e);
   endtask

   // Expected MOVE trace relative to the accept edge (SETTLE=2).
   task automatic push_move(input int base, input logic [7:0] e_oe,
                            input logic [7:0] e_hold, input logic [7:0] e_latch,
                            input bit with_idle, input string tag);
      push(base + 1, e_oe, e_hold, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, {tag, "_drive1"});
      push(base + 2, e_oe, e_hold, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, {tag, "_drive2"});
      push(base + 3, e_oe, e_hold, e_latch, 8'h00, 1'b0, 1'b0, 1'b1, {tag, "_latch"});
      push(base + 4, e_oe, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, {tag, "_release"});
      push(base + 5, 8'h00, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, {tag, "_done"});
      if (with_idle)
         push(base + 6, 8'h00, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, {tag, "_idle"});
   endtask

   // Present a command at a falling edge, hold it through one rising edge,
   // then scramble the fields so only the accept-edge values can matter.
   task automatic issue(input logic [1:0] o, input logic [2:0] s, input logic [2:0] d);
      req = 1'b1; op = o; src = s; dst = d;
      @(posedge CLK);
      #1;
      req = 1'b0; op = 2'd3; src = ~s; dst = ~d;
   endtask

   // Monitor: compare every snapshot due in the current cycle.
   initial begin
      forever begin
         @(negedge CLK);
         while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            chk({e.tag, "_cycle"}, cyc, e.cyc);
            chk({e.tag, "_oe"}, oe, e.oe);
            chk({e.tag, "_hold"}, hold, e.hold);
            chk({e.tag, "_latch"}, latch, e.latch);
            chk({e.tag, "_clr"}, clr, e.clr);
            chk({e.tag, "_ack"}, ack, e.ack);
            chk({e.tag, "_err"}, err, e.err);
            chk({e.tag, "_busy"}, busy, e.busy);
         end
      end
   end

   initial begin
      int base;
      RESET = 1'b1; req = 1'b0; op = '0; src = '0; dst = '0;
      repeat (2) @(negedge CLK);
      chk("reset_oe", oe, 8'h00);
      chk("reset_hold", hold, 8'hFF);
      chk("reset_latch", latch, 8'h00);
      chk("reset_clr", clr, 8'h00);
      chk("reset_ack_err_busy", {ack, err, busy}, 3'b000);
      RESET = 1'b0;

      // Idle with no request.
      base = cyc;
      for (int i = 1; i <= 10; i++)
         push(base + i, 8'h00, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, "idle");
      repeat (10) @(negedge CLK);

      // MOVE reg2 -> reg5.
      base = cyc;
      push_move(base, 8'h04, 8'hDF, 8'h20, 1'b1, "mv2to5");
      issue(2'd0, 3'd2, 3'd5);
      repeat (6) @(negedge CLK);

      // MOVE reg7 -> reg0 (top and bottom indices).
      base = cyc;
      push_move(base, 8'h80, 8'hFE, 8'h01, 1'b1, "mv7to0");
      issue(2'd0, 3'd7, 3'd0);
      repeat (6) @(negedge CLK);

      // CLEAR reg7.
      base = cyc;
      push(base + 1, 8'h00, 8'hFF, 8'h00, 8'h80, 1'b0, 1'b0, 1'b1, "clr7_strobe");
      push(base + 2, 8'h00, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, "clr7_done");
      push(base + 3, 8'h00, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, "clr7_idle");
      issue(2'd1, 3'd3, 3'd7);
      repeat (3) @(negedge CLK);

      // MOVE with src == dst is rejected.
      base = cyc;
      push(base + 1, 8'h00, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, "rej_same_done");
      push(base + 2, 8'h00, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, "rej_same_idle");
      issue(2'd0, 3'd3, 3'd3);
      repeat (2) @(negedge CLK);

      // Reserved opcode is rejected.
      base = cyc;
      push(base + 1, 8'h00, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, "rej_op2_done");
      push(base + 2, 8'h00, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, "rej_op2_idle");
      issue(2'd2, 3'd1, 3'd4);
      repeat (2) @(negedge CLK);

      // req held high: MOVE 1->4, fields change to 6->0 while busy; the
      // second command is accepted at the edge ending the idle cycle.
      base = cyc;
      push_move(base, 8'h02, 8'hEF, 8'h10, 1'b1, "b2b_first");
      push_move(base + 6, 8'h40, 8'hFE, 8'h01, 1'b1, "b2b_second");
      req = 1'b1; op = 2'd0; src = 3'd1; dst = 3'd4;
      @(posedge CLK);
      #1;
      src = 3'd6; dst = 3'd0;
      repeat (6) @(posedge CLK);
      #1;
      req = 1'b0; op = 2'd3; src = 3'd5; dst = 3'd5;
      repeat (6) @(negedge CLK);

      // Reset in the LATCH cycle drops strobes without a clock edge.
      base = cyc;
      push(base + 1, 8'h01, 8'hFD, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, "rst_drive1");
      push(base + 2, 8'h01, 8'hFD, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, "rst_drive2");
      push(base + 3, 8'h01, 8'hFD, 8'h02, 8'h00, 1'b0, 1'b0, 1'b1, "rst_latch");
      issue(2'd0, 3'd0, 3'd1);
      repeat (3) @(negedge CLK);
      #1 RESET = 1'b1;
      #1;
      chk("async_rst_latch", latch, 8'h00);
      chk("async_rst_oe", oe, 8'h00);
      chk("async_rst_hold", hold, 8'hFF);
      chk("async_rst_clr", clr, 8'h00);
      chk("async_rst_busy_ack", {busy, ack}, 2'b00);
      @(negedge CLK);
      RESET = 1'b0;
      @(negedge CLK);

      // A normal MOVE after the aborted one.
      base = cyc;
      push_move(base, 8'h10, 8'hFB, 8'h04, 1'b1, "post_rst_mv4to2");
      issue(2'd0, 3'd4, 3'd2);
      repeat (6) @(negedge CLK);

      repeat (2) @(negedge CLK);
      chk("scoreboard_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Absolute time limit so the run always ends.
   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time limit, got %0d pending expected 0", sb.size());
      errors++;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
